// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage issue controller: default sizes and FSM states.
package id_hazard_ctrl_pkg;

   localparam int unsigned DefAddrWidth  = 5;
   localparam int unsigned DefNumRegs    = 32;
   localparam int unsigned DefMduLatency = 32;
   localparam int unsigned DefCntWidth   = 32;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StHazWait = 2'd1,
      StMduWait = 2'd2
   } hazard_state_e;

endpackage

// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller: pending-write scoreboard for x1..x31, RAW/WAW/MDU
// hazard detection, fetch/decode stall, bubble request and a saturating stall counter.
module id_hazard_ctrl
   import id_hazard_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
   parameter int unsigned NUM_REGS    = DefNumRegs,
   parameter int unsigned MDU_LATENCY = DefMduLatency,
   parameter int unsigned CNT_WIDTH   = DefCntWidth
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dec_valid_i,
   input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
   input  logic                  rs1_used_i,
   input  logic                  rs2_used_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   input  logic                  rd_we_i,
   input  logic                  is_mdu_i,
   input  logic                  wb_en_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  no_op_flag_o,
   output logic                  issue_o,
   output logic [1:0]            state_o,
   output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

   // The issue cycle is the first busy cycle of the MDU, so the counter only has to
   // cover the remaining MDU_LATENCY-1 cycles.
   localparam int unsigned MduCntW = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;

   logic [NUM_REGS-1:0]  pend_q, pend_d;
   logic [MduCntW-1:0]   mdu_cnt_q, mdu_cnt_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   hazard_state_e        state_q, state_d;

   logic raw, waw, strc, haz;

   // Hazard terms and issue/stall decision from the registered scoreboard and MDU counter.
   always_comb begin
      raw  = (rs1_used_i & pend_q[rs1_addr_i] & (rs1_addr_i != '0)) |
             (rs2_used_i & pend_q[rs2_addr_i] & (rs2_addr_i != '0));
      waw  = rd_we_i & (rd_addr_i != '0) & pend_q[rd_addr_i];
      strc = is_mdu_i & (mdu_cnt_q != '0);
      haz  = dec_valid_i & (raw | waw | strc);
      // Reset forces a bubble regardless of what decode presents.
      stall_o      = ~rst & haz & ~flush_i;
      issue_o      = ~rst & dec_valid_i & ~haz & ~flush_i;
      no_op_flag_o = ~issue_o;
   end

   // Next scoreboard, MDU counter, stall counter and FSM state.
   always_comb begin
      pend_d = pend_q;
      if (wb_en_i && (wb_addr_i != '0)) begin
         pend_d[wb_addr_i] = 1'b0;
      end
      // Applied after the clear so a new producer wins over a same-cycle writeback.
      if (issue_o && rd_we_i && (rd_addr_i != '0)) begin
         pend_d[rd_addr_i] = 1'b1;
      end
      pend_d[0] = 1'b0;

      mdu_cnt_d = mdu_cnt_q;
      if (issue_o && is_mdu_i) begin
         mdu_cnt_d = MduCntW'(MDU_LATENCY - 1);
      end else if (mdu_cnt_q != '0) begin
         mdu_cnt_d = mdu_cnt_q - MduCntW'(1);
      end

      stall_cnt_d = stall_cnt_q;
      if (stall_o && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end

      if (flush_i || !haz) begin
         state_d = StRun;
      end else if (strc) begin
         state_d = StMduWait;
      end else begin
         state_d = StHazWait;
      end
   end

   // State registers; reset wipes the scoreboard so in-flight writebacks are forgotten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q      <= '0;
         mdu_cnt_q   <= '0;
         stall_cnt_q <= '0;
         state_q     <= StRun;
      end else begin
         pend_q      <= pend_d;
         mdu_cnt_q   <= mdu_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         state_q     <= state_d;
      end
   end

   assign state_o     = state_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl with a cycle-level reference model and literal pins.
module tb_id_hazard_ctrl;

   localparam int Lat  = 4;
   localparam int CntW = 4;
   localparam int CntMax = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dec_valid = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0, wb_addr = '0;
   logic       u1 = 1'b0, u2 = 1'b0, we = 1'b0, mdu = 1'b0, wb_en = 1'b0, flush = 1'b0;
   logic       stall, noop, issue;
   logic [1:0] state;
   logic [CntW-1:0] scnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit pend_m [32];
   int cyc_m = 0;
   int mdu_cyc_m = 0;
   bit mdu_seen_m = 1'b0;
   int state_m = 0;
   int scnt_m = 0;

   id_hazard_ctrl #(
      .MDU_LATENCY(Lat),
      .CNT_WIDTH  (CntW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .dec_valid_i (dec_valid),
      .rs1_addr_i  (rs1),
      .rs2_addr_i  (rs2),
      .rs1_used_i  (u1),
      .rs2_used_i  (u2),
      .rd_addr_i   (rd),
      .rd_we_i     (we),
      .is_mdu_i    (mdu),
      .wb_en_i     (wb_en),
      .wb_addr_i   (wb_addr),
      .flush_i     (flush),
      .stall_o     (stall),
      .no_op_flag_o(noop),
      .issue_o     (issue),
      .state_o     (state),
      .stall_cnt_o (scnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Model: hazards from pending set and cycles elapsed since the last MDU issue.
   function automatic void m_eval(output bit haz, output bit strc, output bit iss,
                                  output bit stl);
      bit raw, waw;
      raw  = (u1 && rs1 != 0 && pend_m[rs1]) || (u2 && rs2 != 0 && pend_m[rs2]);
      waw  = we && rd != 0 && pend_m[rd];
      strc = mdu && mdu_seen_m && (cyc_m - mdu_cyc_m < Lat);
      haz  = dec_valid && (raw || waw || strc);
      iss  = !rst && dec_valid && !haz && !flush;
      stl  = !rst && haz && !flush;
   endfunction

   always @(posedge clk or posedge rst) begin
      bit haz, strc, iss, stl;
      if (rst) begin
         for (int i = 0; i < 32; i++) pend_m[i] <= 1'b0;
         cyc_m      <= 0;
         mdu_seen_m <= 1'b0;
         state_m    <= 0;
         scnt_m     <= 0;
      end else begin
         m_eval(haz, strc, iss, stl);
         if (stl && scnt_m < CntMax) scnt_m <= scnt_m + 1;
         state_m <= (flush || !haz) ? 0 : (strc ? 2 : 1);
         if (wb_en && wb_addr != 0) pend_m[wb_addr] <= 1'b0;
         if (iss && we && rd != 0) pend_m[rd] <= 1'b1;
         if (iss && mdu) begin
            mdu_seen_m <= 1'b1;
            mdu_cyc_m  <= cyc_m;
         end
         cyc_m <= cyc_m + 1;
      end
   end

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      bit haz, strc, iss, stl;
      m_eval(haz, strc, iss, stl);
      chk("cyc_stall", 32'(stall), 32'(stl));
      chk("cyc_issue", 32'(issue), 32'(iss));
      chk("cyc_noop", 32'(noop), 32'(!iss));
      chk("cyc_state", 32'(state), 32'(state_m));
      chk("cyc_stall_cnt", 32'(scnt), 32'(scnt_m));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input bit v, input int a1, input bit e1, input int a2, input bit e2,
                      input int d, input bit w, input bit m);
      dec_valid = v;
      rs1 = 5'(a1); u1 = e1;
      rs2 = 5'(a2); u2 = e2;
      rd = 5'(d); we = w; mdu = m;
      wb_en = 1'b0; wb_addr = '0; flush = 1'b0;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wb(input int a);
      wb_en = 1'b1;
      wb_addr = 5'(a);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_noop", 32'(noop), 32'd1);
      chk("rst_stall_cnt", 32'(scnt), 32'd0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("init_noop", 32'(noop), 32'd1);
      chk("init_stall", 32'(stall), 32'd0);
      chk("init_stall_cnt", 32'(scnt), 32'd0);
      rst = 1'b0;

      // RAW: addi x5 then add x6,x5,x1, released one cycle after wb of x5
      drv(1, 0, 1, 0, 0, 5, 1, 0); #1 chk("t1_addi_issue", 32'(issue), 32'd1); tick();
      drv(1, 5, 1, 1, 1, 6, 1, 0); #1 chk("t1_raw_stall", 32'(stall), 32'd1); tick();
      chk("t1_state_haz", 32'(state), 32'd1); chk("t1_raw_stall2", 32'(stall), 32'd1); tick();
      wb(5); #1 chk("t1_no_bypass", 32'(stall), 32'd1); tick();
      wb_en = 1'b0; #1 chk("t1_issue", 32'(issue), 32'd1); chk("t1_cnt", 32'(scnt), 32'd3);
      tick();
      idle(); wb(6); tick();

      // MDU structural hazard, latency 4
      do_reset();
      drv(1, 11, 1, 12, 1, 10, 1, 1); #1 chk("t2_div_issue", 32'(issue), 32'd1); tick();
      drv(1, 14, 1, 15, 1, 13, 1, 1); #1 chk("t2_mul_stall1", 32'(stall), 32'd1); tick();
      chk("t2_state_mdu", 32'(state), 32'd2); chk("t2_mul_stall2", 32'(stall), 32'd1); tick();
      chk("t2_mul_stall3", 32'(stall), 32'd1); tick();
      chk("t2_mul_issue", 32'(issue), 32'd1); chk("t2_cnt", 32'(scnt), 32'd3); tick();
      idle(); wb(10); tick(); wb(13); tick();

      // Same-cycle wb and new producer of x7; x0 never tracked
      drv(1, 0, 0, 0, 0, 7, 1, 0); wb(7); #1 chk("t3_x7_issue", 32'(issue), 32'd1); tick();
      drv(1, 7, 1, 0, 0, 8, 1, 0); #1 chk("t3_x7_pending", 32'(stall), 32'd1); tick();
      wb(7); #1 chk("t3_x7_wb_stall", 32'(stall), 32'd1); tick();
      wb_en = 1'b0; #1 chk("t3_x7_issue2", 32'(issue), 32'd1); tick();
      idle(); wb(8); tick();
      drv(1, 0, 0, 0, 0, 0, 1, 0); wb(0); #1 chk("t3_x0_issue", 32'(issue), 32'd1); tick();
      drv(1, 0, 1, 0, 1, 0, 1, 0); #1 chk("t3_x0_nostall", 32'(stall), 32'd0);
      chk("t3_x0_issue2", 32'(issue), 32'd1); tick();

      // Flush beats a RAW stall; the pending bit survives
      drv(1, 0, 0, 0, 0, 20, 1, 0); tick();
      drv(1, 20, 1, 0, 0, 21, 1, 0); flush = 1'b1; #1
      chk("t4_flush_stall", 32'(stall), 32'd0); chk("t4_flush_issue", 32'(issue), 32'd0);
      chk("t4_flush_noop", 32'(noop), 32'd1); tick();
      flush = 1'b0; #1 chk("t4_state_run", 32'(state), 32'd0);
      chk("t4_still_pend", 32'(stall), 32'd1); tick();
      wb(20); tick(); wb_en = 1'b0; tick();
      idle(); wb(21); tick();

      // Saturating stall counter
      drv(1, 0, 0, 0, 0, 9, 1, 0); tick();
      drv(1, 9, 1, 0, 0, 0, 0, 0); repeat (18) tick();
      chk("sat_cnt", 32'(scnt), 32'(CntMax)); chk("sat_stall", 32'(stall), 32'd1);
      wb(9); tick(); wb_en = 1'b0; #1 chk("sat_issue", 32'(issue), 32'd1); tick();

      // Async reset during MDU_WAIT with x1..x5 pending
      for (int r = 2; r <= 5; r++) begin
         drv(1, 0, 0, 0, 0, r, 1, 0); tick();
      end
      drv(1, 0, 0, 0, 0, 1, 1, 1); tick();
      drv(1, 0, 0, 0, 0, 6, 1, 1); tick();
      chk("t5_state_mdu", 32'(state), 32'd2); chk("t5_stall", 32'(stall), 32'd1);
      rst = 1'b1; #1
      chk("t5_rst_noop", 32'(noop), 32'd1); chk("t5_rst_cnt", 32'(scnt), 32'd0);
      chk("t5_rst_state", 32'(state), 32'd0); chk("t5_rst_stall", 32'(stall), 32'd0);
      tick();
      rst = 1'b0;
      drv(1, 1, 1, 2, 1, 6, 1, 1); #1 chk("t5_dep_issue", 32'(issue), 32'd1);
      chk("t5_dep_nostall", 32'(stall), 32'd0); tick();
      idle(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
